lm_sm_sequencer: RTL and testbench
==================================

Name: lm_sm_sequencer

Overview:
- Memory-stage sequencer that sits directly upstream of the data memory and drives its address, enable, write-enable and write-data inputs.
- Executes the load-multiple (LM) and store-multiple (SM) instructions. One register is transferred per cycle, at consecutive addresses starting from a base address.
- Single loads and stores pass through untouched. The block takes over the memory port only while an LM/SM is in progress, and stalls the upstream pipeline during that time.

Parameters:
DATA_W, 16, data and address width
NREG, 8, number of architectural registers; also the width of the register mask
REG_AW, 3, register index width (log2 NREG)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous reset, active-low (0 = reset)
start  in  1  one-cycle request to begin an LM/SM; sampled only in IDLE
is_store  in  1  1 = SM, 0 = LM; captured with start
base_addr  in  DATA_W  first memory address; captured with start
reg_mask  in  NREG  bit k set = transfer register Rk; captured with start
pass_addr  in  DATA_W  address from the normal single load/store path
pass_en  in  1  memory enable from the normal path
pass_wr_en  in  1  memory write-enable from the normal path
pass_wdata  in  DATA_W  write data from the normal path
mem_rdata  in  DATA_W  data memory read output, combinational, same cycle
rf_rd_data  in  DATA_W  register file read data, combinational
mem_addr  out  DATA_W  to data memory address
mem_en  out  1  to data memory enable
mem_wr_en  out  1  to data memory write-enable
mem_wdata  out  DATA_W  to data memory write data
rf_rd_addr  out  REG_AW  register index for SM read
rf_wr_en  out  1  register file write strobe for LM
rf_wr_addr  out  REG_AW  LM destination register
rf_wr_data  out  DATA_W  LM write data
stall  out  1  freeze upstream stages
done  out  1  one-cycle completion pulse

Behaviour:
- States:
  - IDLE: outputs mirror the pass_* inputs; rf_wr_en=0; stall=0; done=0.
  - ACCESS: the sequencer owns the memory port.
  - DONE: one cycle; outputs mirror pass_*; stall=0; done=1; then returns to IDLE.
- Registers: state, addr_q (DATA_W), mask_q (NREG), store_q.
- Reset (asynchronous, reset=0):
  - state=IDLE, addr_q=0, mask_q=0, store_q=0.
  - In-flight transfers are aborted; no further memory or register writes occur.
  - All sequencer-driven outputs go to 0 immediately. mem_* outputs mirror pass_* as in IDLE.
- IDLE with start=1:
  - Capture is_store, base_addr and reg_mask.
  - If reg_mask != 0, go to ACCESS. If reg_mask == 0, go to DONE; no memory access occurs.
- ACCESS, each cycle:
  - Index k = lowest set bit of mask_q (priority encoder, bit 0 first).
  - mem_addr=addr_q, mem_en=1, stall=1.
  - For SM (store_q=1): rf_rd_addr=k, mem_wdata=rf_rd_data, mem_wr_en=1; the memory writes on the rising edge. rf_wr_en=0.
  - For LM (store_q=0): mem_wr_en=0, rf_wr_en=1, rf_wr_addr=k, rf_wr_data=mem_rdata; the register file writes on the rising edge.
  - On the edge: clear bit k in mask_q and set addr_q = addr_q + 1 (modulo 2^DATA_W; 16'hFFFF wraps to 0).
  - If the cleared mask becomes 0, go to DONE.
- Latency: start edge, then N ACCESS cycles (N = popcount of reg_mask), then 1 DONE cycle, then IDLE. A mask of 0 gives a single DONE cycle.
- Addresses are consecutive regardless of gaps in the mask: the i-th transferred register uses base+i.
- start asserted in ACCESS or DONE is ignored; the upstream stall makes re-issue the requester's duty.
- pass_* inputs are ignored in ACCESS, and the sequencer never drives mem_wr_en from them in that state.
- All outputs are combinational from registered state and inputs; there is no output register stage.

Test Plan:
- Memory preloaded with [10]=15, [11]=20, [12]=25. LM with base=10, mask=8'b00000101 -> cycle 1: rf_wr_en, R0<=15, mem_addr=10; cycle 2: R2<=20, mem_addr=11; cycle 3: done=1, stall=0.
- SM with base=20, mask=8'hFF, Rk=100+k -> 8 ACCESS cycles with mem_wr_en=1, then mem[20..27]=100..107, stall high for exactly 8 cycles, then done.
- start with mask=0 -> done=1 on the next cycle; mem_en from the sequencer never asserted; stall stays 0; rf_wr_en stays 0.
- LM with base=16'hFFFF, mask=8'b10000001 -> R0 loaded from address FFFF, R7 loaded from address 0000.
- LM with mask=8'hFF and reset pulled low after 2 accesses -> only R0 and R1 written; outputs drop immediately; state IDLE; no done pulse. A start after reset release runs normally.
- Second start pulsed mid-SM with different base and mask -> ignored; the original transfer completes unchanged. pass_wr_en=1 during ACCESS never reaches mem_wr_en except through the SM path.

Source files
------------

// File: rtl/lm_sm_sequencer_if.sv
// Data memory port driven by the LM/SM sequencer.
// The master (sequencer) drives address, enable, write-enable and write data.
// The slave (memory) returns combinational read data.
interface lm_sm_sequencer_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_en,
    output mem_wr_en,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_en,
    input  mem_wr_en,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer in front of the data memory.
// It transfers one register per cycle at consecutive addresses and owns the memory
// port only while a transfer is in progress. Outside a transfer, the normal
// single load/store path passes straight through.
module lm_sm_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned REG_AW = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                is_store,
  input  logic [DATA_W-1:0]   base_addr,
  input  logic [NREG-1:0]     reg_mask,
  input  logic [DATA_W-1:0]   pass_addr,
  input  logic                pass_en,
  input  logic                pass_wr_en,
  input  logic [DATA_W-1:0]   pass_wdata,
  input  logic [DATA_W-1:0]   rf_rd_data,
  lm_sm_sequencer_if.master   mem,
  output logic [REG_AW-1:0]   rf_rd_addr,
  output logic                rf_wr_en,
  output logic [REG_AW-1:0]   rf_wr_addr,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic                stall,
  output logic                done
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] addr_q;
  logic [NREG-1:0]   mask_q;
  logic              store_q;

  logic [REG_AW-1:0] idx;
  logic [NREG-1:0]   mask_clr;
  logic              in_access;
  logic              sm_active;
  logic              lm_active;

  // Priority encoder: the lowest set mask bit is the register served this cycle.
  always_comb begin
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (mask_q[i]) idx = REG_AW'(i);
    end
  end

  // Clearing the lowest set bit is the same as clearing bit idx.
  assign mask_clr  = mask_q & (mask_q - NREG'(1));
  assign in_access = (state_q == StAccess);
  assign sm_active = in_access && store_q;
  assign lm_active = in_access && !store_q;

  // Sequencer state: capture the request, then walk the mask one register per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      mask_q  <= '0;
      store_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            store_q <= is_store;
            addr_q  <= base_addr;
            mask_q  <= reg_mask;
            state_q <= (reg_mask != '0) ? StAccess : StDone;
          end
        end
        StAccess: begin
          mask_q <= mask_clr;
          addr_q <= addr_q + DATA_W'(1);
          if (mask_clr == '0) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Control outputs: mirror the pass path unless a transfer owns the port.
  always_comb begin
    mem.mem_addr  = pass_addr;
    mem.mem_en    = pass_en;
    mem.mem_wr_en = pass_wr_en;
    rf_rd_addr    = '0;
    rf_wr_en      = 1'b0;
    rf_wr_addr    = '0;
    stall         = 1'b0;
    done          = (state_q == StDone);
    if (in_access) begin
      mem.mem_addr  = addr_q;
      mem.mem_en    = 1'b1;
      mem.mem_wr_en = store_q;
      stall         = 1'b1;
      if (store_q) begin
        rf_rd_addr = idx;
      end else begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = idx;
      end
    end
  end

  // Data paths are kept apart from the control block so the combinational memory
  // and register-file reads do not form a false loop through one process.
  assign mem.mem_wdata = sm_active ? rf_rd_data :
                         (in_access ? '0 : pass_wdata);
  assign rf_wr_data    = lm_active ? mem.mem_rdata : '0;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [2:0]  idx;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic [15:0] pass_addr;
  logic        pass_en;
  logic        pass_wr_en;
  logic [15:0] pass_wdata;
  logic [15:0] rf_rd_data;
  logic [2:0]  rf_rd_addr;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic        stall;
  logic        done;

  lm_sm_sequencer_if #(.DATA_W(16)) bus ();

  lm_sm_sequencer #(
    .DATA_W(16),
    .NREG  (8),
    .REG_AW(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .reg_mask  (reg_mask),
    .pass_addr (pass_addr),
    .pass_en   (pass_en),
    .pass_wr_en(pass_wr_en),
    .pass_wdata(pass_wdata),
    .rf_rd_data(rf_rd_data),
    .mem       (bus),
    .rf_rd_addr(rf_rd_addr),
    .rf_wr_en  (rf_wr_en),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .stall     (stall),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: 256-word memory (indexed by the low address byte) and 8-entry register file.
  logic [15:0] mem [256];
  logic [15:0] rf  [8];
  bit          init_done = 1'b0;

  function automatic logic [15:0] mem_init(input int a);
    if (a == 10) return 16'd15;
    if (a == 11) return 16'd20;
    if (a == 12) return 16'd25;
    if (a == 255) return 16'h1111;
    if (a == 0) return 16'h2222;
    if (a >= 30 && a <= 37) return 16'(200 + a - 30);
    return 16'hEE00 | 16'(a);
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
      for (int k = 0; k < 8; k++) rf[k] <= 16'(100 + k);
      init_done <= 1'b1;
    end else begin
      if (bus.mem_en && bus.mem_wr_en) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    end
  end

  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  assign rf_rd_data    = rf[rf_rd_addr];

  // Reference model and scoreboard.
  logic [15:0] exp_mem [256];
  logic [15:0] exp_rf  [8];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic st, input logic [15:0] base, input logic [7:0] m,
                        input bit inject);
    int          n      = 0;
    int          cyc    = 0;
    int          stalls = 0;
    bit          seen   = 1'b0;
    logic [15:0] a;
    exp_t        e;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        a = base + 16'(n);
        if (st) begin
          sb.push_back('{wr: 1'b1, addr: a, idx: 3'(k), data: exp_rf[k]});
          exp_mem[a[7:0]] = exp_rf[k];
        end else begin
          sb.push_back('{wr: 1'b0, addr: a, idx: 3'(k), data: exp_mem[a[7:0]]});
          exp_rf[k] = exp_mem[a[7:0]];
        end
        n++;
      end
    end
    @(posedge clk);
    #1;
    start     = 1'b1;
    is_store  = st;
    base_addr = base;
    reg_mask  = m;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = 16'h7777;
    reg_mask  = 8'hAA;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        stalls++;
        check("acc_mem_en", bus.mem_en, 1'b1);
        check("acc_done", done, 1'b0);
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("acc_addr", bus.mem_addr, e.addr);
          check("acc_wr_en", bus.mem_wr_en, e.wr);
          check("acc_rf_wr_en", rf_wr_en, !e.wr);
          if (e.wr) begin
            check("sm_rd_addr", rf_rd_addr, e.idx);
            check("sm_wdata", bus.mem_wdata, e.data);
          end else begin
            check("lm_wr_addr", rf_wr_addr, e.idx);
            check("lm_wr_data", rf_wr_data, e.data);
          end
        end
        if (inject && stalls == 2) begin
          start     = 1'b1;
          is_store  = !st;
          base_addr = 16'h0100;
          reg_mask  = 8'h0F;
        end else begin
          start = 1'b0;
        end
      end else begin
        check("idle_mem_en", bus.mem_en, pass_en);
        check("idle_rf_wr_en", rf_wr_en, 1'b0);
        if (done) seen = 1'b1;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1'b1);
    check("stall_cycles", stalls, n);
    check("sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_stall", stall, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = mem_init(i);
    for (int k = 0; k < 8; k++) exp_rf[k] = 16'(100 + k);
    reset      = 1'b0;
    start      = 1'b0;
    is_store   = 1'b0;
    base_addr  = '0;
    reg_mask   = '0;
    pass_addr  = 16'h5555;
    pass_en    = 1'b0;
    pass_wr_en = 1'b0;
    pass_wdata = 16'hDEAD;

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rf_wr_en", rf_wr_en, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 16'h5555);
    check("rst_mem_en", bus.mem_en, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // SM of all eight registers to 20..27.
    run_op(1'b1, 16'd20, 8'hFF, 1'b0);
    // LM with a gap in the mask: R0 <- [10], R2 <- [11].
    run_op(1'b0, 16'd10, 8'b0000_0101, 1'b0);
    check("lm_r0", rf[0], 16'd15);
    check("lm_r2", rf[2], 16'd20);
    // Empty mask: a single done cycle, no memory access.
    run_op(1'b0, 16'd50, 8'h00, 1'b0);
    // Address wrap from FFFF to 0000.
    run_op(1'b0, 16'hFFFF, 8'b1000_0001, 1'b0);
    check("wrap_r0", rf[0], 16'h1111);
    check("wrap_r7", rf[7], 16'h2222);
    // SM with a second start injected mid-transfer and pass_wr_en held high.
    pass_en    = 1'b1;
    pass_wr_en = 1'b1;
    run_op(1'b1, 16'd40, 8'h3C, 1'b1);

    // LM aborted by reset after two accesses.
    @(posedge clk);
    #1;
    start     = 1'b1;
    is_store  = 1'b0;
    base_addr = 16'd30;
    reg_mask  = 8'hFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("abort_addr0", bus.mem_addr, 16'd30);
    @(negedge clk);
    check("abort_addr1", bus.mem_addr, 16'd31);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_stall", stall, 1'b0);
    check("abort_rf_wr_en", rf_wr_en, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_mem_addr", bus.mem_addr, 16'h5555);
    check("abort_mem_wr_en", bus.mem_wr_en, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_rf[0] = 16'd200;
    exp_rf[1] = 16'd201;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
      check("abort_no_stall", stall, 1'b0);
    end
    // Normal LM after reset release: R1 <- [10].
    run_op(1'b0, 16'd10, 8'b0000_0010, 1'b0);
    check("post_rst_r1", rf[1], 16'd15);

    @(negedge clk);
    for (int k = 0; k < 8; k++) check("final_rf", rf[k], exp_rf[k]);
    for (int i = 20; i < 28; i++) check("final_mem_sm", mem[i], exp_mem[i]);
    for (int i = 40; i < 44; i++) check("final_mem_inj", mem[i], exp_mem[i]);
    check("inj_base_untouched", mem[0], exp_mem[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
